// File: rtl/instruction_fetch_sequencer_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_sequencer_if
// Byte-memory read channel plus the Instruction Register write controls used
// by the fetch sequencer.
//
// Handshake: the sequencer (master) raises mem_read with a stable mem_address
// and holds both until the memory (slave) answers with mem_valid. A byte is
// transferred in every cycle where mem_read && mem_valid. The byte travels
// straight from memory into the IR, so ir_write/ir_lh are asserted in that
// same cycle to steer it into the low (ir_lh=0) or high (ir_lh=1) half.
//
// Signals:
//   mem_read     master->slave  read request, held until mem_valid
//   mem_address  master->slave  byte address of the request
//   mem_valid    slave->master  read data byte valid this cycle
//   ir_write     master->IR     write the returned byte into the IR
//   ir_lh        master->IR     0 = low byte, 1 = high byte
// ----------------------------------------------------------------------------
interface instruction_fetch_sequencer_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  mem_read;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_valid;
  logic                  ir_write;
  logic                  ir_lh;

  modport master (
    output mem_read,
    output mem_address,
    output ir_write,
    output ir_lh,
    input  mem_valid
  );

  modport slave (
    input  mem_read,
    input  mem_address,
    input  ir_write,
    input  ir_lh,
    output mem_valid
  );
endinterface

// File: rtl/instruction_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// instruction_fetch_sequencer
// Fetches a 16-bit instruction from byte-wide memory as two reads (low byte at
// PC, high byte at PC+1), steering each byte into the matching IR half, then
// pulses a PC increment (+2) and an instruction-valid strobe. A per-byte wait
// counter aborts a fetch whose memory never answers.
//
// Ports:
//   i_clk          system clock, all state on posedge
//   i_rst          synchronous active-high reset
//   i_fetch_req    level request to fetch the instruction at i_pc_value
//   i_flush        abort any fetch in progress
//   i_pc_value     current PC, sampled when a fetch is accepted
//   bus            memory / IR control interface (master side)
//   o_pc_inc       one-cycle pulse, PC owner adds 2
//   o_instr_valid  one-cycle pulse, IR holds the new instruction
//   o_fetch_error  one-cycle pulse, memory timeout abort
//   o_busy         high while a byte read is outstanding
//   o_state        FSM state: 0 IDLE, 1 REQ_LO, 2 REQ_HI, 3 DONE
// ----------------------------------------------------------------------------
module instruction_fetch_sequencer #(
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 15
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_fetch_req,
  input  logic                          i_flush,
  input  logic [ADDR_WIDTH-1:0]         i_pc_value,
  instruction_fetch_sequencer_if.master bus,
  output logic                          o_pc_inc,
  output logic                          o_instr_valid,
  output logic                          o_fetch_error,
  output logic                          o_busy,
  output logic [1:0]                    o_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ_LO = 2'd1,
    S_REQ_HI = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_W-1:0]      r_wait_cnt;

  logic w_in_req;
  logic w_byte_done;
  logic w_timeout;
  logic w_quiet;

  assign w_in_req    = (r_state == S_REQ_LO) || (r_state == S_REQ_HI);
  assign w_byte_done = w_in_req && bus.mem_valid;
  // A byte arriving in the last allowed wait cycle wins over the timeout.
  assign w_timeout   = w_in_req && !bus.mem_valid && (r_wait_cnt == CNT_LAST);
  // Reset and flush both discard the current cycle, so no pulse may escape.
  assign w_quiet     = i_rst || i_flush;

  // Moore outputs decode the state register; IR write and PC increment follow
  // mem_valid in the same cycle because the byte goes straight into the IR.
  assign bus.mem_read    = w_in_req;
  assign bus.mem_address = w_in_req ? r_addr : '0;
  assign bus.ir_lh       = (r_state == S_REQ_HI);
  assign bus.ir_write    = w_byte_done && !w_quiet;
  assign o_pc_inc        = w_byte_done && (r_state == S_REQ_HI) && !w_quiet;
  assign o_instr_valid   = (r_state == S_DONE) && !w_quiet;
  assign o_fetch_error   = w_timeout && !w_quiet;
  assign o_busy          = w_in_req;
  assign o_state         = r_state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wait_cnt <= '0;
    end else if (i_flush) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_fetch_req) begin
            r_addr     <= i_pc_value;
            r_wait_cnt <= '0;
            r_state    <= S_REQ_LO;
          end
        end
        S_REQ_LO: begin
          if (bus.mem_valid) begin
            // High byte lives at the next address, wrapping at the top.
            r_addr     <= r_addr + ADDR_WIDTH'(1);
            r_wait_cnt <= '0;
            r_state    <= S_REQ_HI;
          end else if (w_timeout) begin
            r_wait_cnt <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        S_REQ_HI: begin
          if (bus.mem_valid) begin
            r_wait_cnt <= '0;
            r_state    <= S_DONE;
          end else if (w_timeout) begin
            r_wait_cnt <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          // A held request chains straight into the next fetch; the PC owner
          // has already applied the +2, so i_pc_value is the new address.
          if (i_fetch_req) begin
            r_addr     <= i_pc_value;
            r_wait_cnt <= '0;
            r_state    <= S_REQ_LO;
          end else begin
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
module tb_instruction_fetch_sequencer;
  localparam int AW      = 16;
  localparam int TIMEOUT = 15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          fetch_req;
  logic          flush;
  logic [AW-1:0] pc_value;
  logic          pc_inc;
  logic          instr_valid;
  logic          fetch_error;
  logic          busy;
  logic [1:0]    state;

  instruction_fetch_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  instruction_fetch_sequencer #(.ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_fetch_req   (fetch_req),
    .i_flush       (flush),
    .i_pc_value    (pc_value),
    .bus           (bus),
    .o_pc_inc      (pc_inc),
    .o_instr_valid (instr_valid),
    .o_fetch_error (fetch_error),
    .o_busy        (busy),
    .o_state       (state)
  );

  // ---------------- memory and IR models ----------------
  logic [7:0]  mem [0:65535];
  logic [15:0] ir_out = '0;

  always @(posedge clk) begin
    if (bus.ir_write === 1'b1) begin
      if (bus.ir_lh) ir_out[15:8] <= mem[bus.mem_address];
      else           ir_out[7:0]  <= mem[bus.mem_address];
    end
  end

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] sb_exp;
  bit          expect_done = 1'b0;
  int          pc_inc_seen = 0;
  int          pc_inc_exp  = 0;
  logic [AW-1:0] pc_model;

  always @(negedge clk) begin
    #2;
    if (pc_inc === 1'b1) pc_inc_seen++;
    if (instr_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: instr_valid with ir=%h, none expected", ir_out);
      end else begin
        sb_exp = exp_q.pop_front();
        if (ir_out !== sb_exp) begin
          n_err++;
          $display("FAIL sb_ir: got ir=%h expected %h", ir_out, sb_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present a request in an IDLE or DONE cycle.
  task automatic accept(input logic [AW-1:0] pc);
    @(negedge clk);
    fetch_req = 1'b1; pc_value = pc; bus.mem_valid = 1'b0; flush = 1'b0;
    #1;
    n_cmp++;
    if (state !== (expect_done ? ST_DONE : ST_IDLE)) begin
      n_err++;
      $display("FAIL accept_state: got %0d expected %0d", state, expect_done ? ST_DONE : ST_IDLE);
    end
    n_cmp++;
    if (instr_valid !== expect_done || bus.ir_write !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL accept_outs: instr_valid=%b ir_write=%b busy=%b expected %b 0 0",
               instr_valid, bus.ir_write, busy, expect_done);
    end
    expect_done = 1'b0;
  endtask

  // Serve one byte after 'waits' cycles of mem_valid low.
  task automatic serve_byte(input logic [AW-1:0] addr, input bit hi, input int waits, input bit req);
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      fetch_req = req; bus.mem_valid = 1'b0;
      #1;
      n_cmp++;
      if (bus.mem_read !== 1'b1 || bus.mem_address !== addr || busy !== 1'b1 ||
          bus.ir_write !== 1'b0 || pc_inc !== 1'b0 || fetch_error !== 1'b0) begin
        n_err++;
        $display("FAIL wait_cycle: rd=%b addr=%h busy=%b irw=%b inc=%b err=%b expected 1 %h 1 0 0 0",
                 bus.mem_read, bus.mem_address, busy, bus.ir_write, pc_inc, fetch_error, addr);
      end
    end
    @(negedge clk);
    fetch_req = req; bus.mem_valid = 1'b1;
    #1;
    n_cmp++;
    if (bus.mem_read !== 1'b1 || bus.mem_address !== addr || bus.ir_write !== 1'b1 ||
        bus.ir_lh !== hi || pc_inc !== hi || fetch_error !== 1'b0) begin
      n_err++;
      $display("FAIL byte_xfer: rd=%b addr=%h irw=%b lh=%b inc=%b err=%b expected 1 %h 1 %b %b 0",
               bus.mem_read, bus.mem_address, bus.ir_write, bus.ir_lh, pc_inc, fetch_error, addr, hi, hi);
    end
  endtask

  // Complete fetch: the expected word comes straight from the memory contents.
  task automatic run_fetch(input logic [AW-1:0] pc, input int lo_w, input int hi_w, input bit req);
    logic [AW-1:0] pc1;
    pc1 = pc + AW'(1);
    accept(pc);
    exp_q.push_back({mem[pc1], mem[pc]});
    serve_byte(pc, 1'b0, lo_w, req);
    serve_byte(pc1, 1'b1, hi_w, req);
    pc_inc_exp++;
    pc_model = pc + AW'(2);
    expect_done = 1'b1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    fetch_req = 1'b0; bus.mem_valid = 1'b0; flush = 1'b0;
    #1;
    n_cmp++;
    if (instr_valid !== expect_done || bus.ir_write !== 1'b0) begin
      n_err++;
      $display("FAIL idle_outs: instr_valid=%b ir_write=%b expected %b 0", instr_valid, bus.ir_write, expect_done);
    end
    expect_done = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; fetch_req = 1'b0; flush = 1'b0; pc_value = '0; bus.mem_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_cmp++;
    if (bus.mem_read !== 1'b0 || bus.mem_address !== '0 || bus.ir_write !== 1'b0 || bus.ir_lh !== 1'b0) begin
      n_err++;
      $display("FAIL reset_bus: rd=%b addr=%h irw=%b lh=%b expected all 0", bus.mem_read, bus.mem_address, bus.ir_write, bus.ir_lh);
    end
    n_cmp++;
    if (pc_inc !== 1'b0 || instr_valid !== 1'b0 || fetch_error !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctl: inc=%b iv=%b err=%b busy=%b expected all 0", pc_inc, instr_valid, fetch_error, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int inc0;
    inc0 = pc_inc_exp;
    mem[16'h0040] = 8'h34;
    mem[16'h0041] = 8'h12;
    run_fetch(16'h0040, 0, 0, 1'b0);
    idle_cycle();
    n_cmp++;
    if (ir_out !== 16'h1234) begin n_err++; $display("FAIL basic_ir: got %h expected 1234", ir_out); end
    n_cmp++;
    if (pc_inc_seen !== inc0 + 1) begin n_err++; $display("FAIL basic_pcinc: got %0d expected %0d", pc_inc_seen, inc0 + 1); end
    idle_cycle();
    n_cmp++;
    if (state !== ST_IDLE) begin n_err++; $display("FAIL basic_idle: got %0d expected 0", state); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] top;
    logic [AW-1:0] zero;
    top = 16'hFFFF; zero = 16'h0000;
    mem[top] = 8'hA5; mem[zero] = 8'h5C;
    run_fetch(top, 1, 2, 1'b0);
    idle_cycle();
    n_cmp++;
    if (ir_out !== 16'h5CA5) begin n_err++; $display("FAIL wrap_ir: got %h expected 5ca5", ir_out); end
  endtask

  task automatic test_timeout();
    int inc0;
    inc0 = pc_inc_seen;
    accept(16'h0100);
    serve_byte(16'h0100, 1'b0, 0, 1'b0);
    for (int w = 0; w < TIMEOUT; w++) begin
      @(negedge clk);
      bus.mem_valid = 1'b0;
      #1;
      n_cmp++;
      if (bus.mem_read !== 1'b1 || bus.mem_address !== 16'h0101 || pc_inc !== 1'b0 ||
          fetch_error !== (w == TIMEOUT - 1)) begin
        n_err++;
        $display("FAIL timeout_wait%0d: rd=%b addr=%h inc=%b err=%b expected 1 0101 0 %b",
                 w, bus.mem_read, bus.mem_address, pc_inc, fetch_error, (w == TIMEOUT - 1));
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (state !== ST_IDLE || busy !== 1'b0 || fetch_error !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_after: state=%0d busy=%b err=%b iv=%b expected 0 0 0 0", state, busy, fetch_error, instr_valid);
    end
    n_cmp++;
    if (pc_inc_seen !== inc0) begin n_err++; $display("FAIL timeout_pcinc: got %0d expected %0d", pc_inc_seen, inc0); end
  endtask

  task automatic test_flush();
    logic [7:0] hi_before;
    accept(16'h0200);
    serve_byte(16'h0200, 1'b0, 0, 1'b0);
    hi_before = ir_out[15:8];
    mem[16'h0201] = ~hi_before;
    @(negedge clk);
    bus.mem_valid = 1'b1; flush = 1'b1;
    #1;
    n_cmp++;
    if (bus.ir_write !== 1'b0 || pc_inc !== 1'b0 || fetch_error !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_hi: irw=%b inc=%b err=%b iv=%b expected all 0", bus.ir_write, pc_inc, fetch_error, instr_valid);
    end
    @(negedge clk);
    bus.mem_valid = 1'b0; flush = 1'b0;
    #1;
    n_cmp++;
    if (state !== ST_IDLE) begin n_err++; $display("FAIL flush_state: got %0d expected 0", state); end
    n_cmp++;
    if (ir_out[15:8] !== hi_before) begin n_err++; $display("FAIL flush_irhi: got %h expected %h", ir_out[15:8], hi_before); end
    // Flush in DONE suppresses InstrValid and beats a pending request.
    run_fetch(16'h0300, 0, 0, 1'b0);
    @(negedge clk);
    flush = 1'b1; fetch_req = 1'b1; bus.mem_valid = 1'b0;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0) begin n_err++; $display("FAIL flush_done_iv: got %b expected 0", instr_valid); end
    void'(exp_q.pop_back());
    expect_done = 1'b0;
    @(negedge clk);
    flush = 1'b0; fetch_req = 1'b0;
    #1;
    n_cmp++;
    if (state !== ST_IDLE) begin n_err++; $display("FAIL flush_done_state: got %0d expected 0", state); end
  endtask

  task automatic test_back_to_back();
    pc_model = 16'h0010;
    for (int i = 0; i < 3; i++) run_fetch(pc_model, 0, 0, 1'b1);
    idle_cycle();
    n_cmp++;
    if (pc_model !== 16'h0016) begin n_err++; $display("FAIL b2b_pc: got %h expected 0016", pc_model); end
  endtask

  task automatic test_idle_ignore();
    logic [15:0] ir_before;
    idle_cycle();
    ir_before = ir_out;
    @(negedge clk);
    fetch_req = 1'b0; bus.mem_valid = 1'b1;
    #1;
    n_cmp++;
    if (bus.ir_write !== 1'b0 || bus.mem_read !== 1'b0) begin
      n_err++;
      $display("FAIL idle_memvalid: irw=%b rd=%b expected 0 0", bus.ir_write, bus.mem_read);
    end
    @(negedge clk);
    bus.mem_valid = 1'b0;
    #1;
    n_cmp++;
    if (state !== ST_IDLE || ir_out !== ir_before) begin
      n_err++;
      $display("FAIL idle_stay: state=%0d ir=%h expected 0 %h", state, ir_out, ir_before);
    end
  endtask

  task automatic test_reset_mid_fetch();
    accept(16'h0400);
    @(negedge clk);
    fetch_req = 1'b0; bus.mem_valid = 1'b1; rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.ir_write !== 1'b0 || pc_inc !== 1'b0 || fetch_error !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_pulses: irw=%b inc=%b err=%b expected 0 0 0", bus.ir_write, pc_inc, fetch_error);
    end
    @(negedge clk);
    rst = 1'b0; bus.mem_valid = 1'b0;
    #1;
    n_cmp++;
    if (state !== ST_IDLE || bus.mem_read !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_state: state=%0d rd=%b expected 0 0", state, bus.mem_read);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_fetch(AW'($urandom_range(0, 65535)), $urandom_range(0, TIMEOUT - 1),
                $urandom_range(0, TIMEOUT - 1), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    test_reset();
    test_basic();
    test_wrap();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_idle_ignore();
    test_reset_mid_fetch();
    test_random();
    idle_cycle();
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_leftover: %0d fetches never reported, expected 0", exp_q.size()); end
    n_cmp++;
    if (pc_inc_seen !== pc_inc_exp) begin n_err++; $display("FAIL pcinc_total: got %0d expected %0d", pc_inc_seen, pc_inc_exp); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
